// File: rtl/video_mem_scheduler.sv
// video_mem_scheduler: time-division arbiter for the single-port pixel RAM.
// Scanout reads always win. Two writers share the blanking time round-robin,
// and a short guard band ahead of every visible line keeps writes out of
// scanout's way.
module video_mem_scheduler #(
  parameter int H_VISIBLE = 640,
  parameter int H_TOTAL   = 800,
  parameter int V_VISIBLE = 480,
  parameter int V_TOTAL   = 525,
  parameter int GUARD     = 2,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [9:0]        i_hpos,
  input  logic [9:0]        i_vpos,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_wr0_valid,
  input  logic [ADDR_W-1:0] i_wr0_addr,
  input  logic [DATA_W-1:0] i_wr0_data,
  output logic              o_wr0_ready,
  input  logic              i_wr1_valid,
  input  logic [ADDR_W-1:0] i_wr1_addr,
  input  logic [DATA_W-1:0] i_wr1_data,
  output logic              o_wr1_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_state,
  output logic              o_frame_start
);

  typedef enum logic [1:0] {
    ST_BLANK  = 2'b00,
    ST_GUARD  = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  // Window boundaries sized to the counter width.
  localparam logic [9:0] H_VIS_L      = 10'(H_VISIBLE);
  localparam logic [9:0] H_PRE_L      = 10'(H_TOTAL - GUARD);
  localparam logic [9:0] V_VIS_L      = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST_VIS_L = 10'(V_VISIBLE - 1);
  localparam logic [9:0] V_LAST_L     = 10'(V_TOTAL - 1);

  state_t state_reg, state_next;
  logic   rr_reg, rr_next;          // last granted writer: 0 = wr0, 1 = wr1
  logic   rd_valid_reg;
  logic   frame_start_reg, frame_start_next;
  logic   visible, pre;
  logic   grant0, grant1;

  // Next state, frame-start detect and arbitration for the current cycle.
  always_comb begin
    visible          = (i_vpos < V_VIS_L) && (i_hpos < H_VIS_L);
    // The last visible line is followed by vertical blanking, so it never
    // needs a guard; the final line of the frame guards line 0.
    pre              = (i_hpos >= H_PRE_L) &&
                       ((i_vpos < V_LAST_VIS_L) || (i_vpos == V_LAST_L));
    state_next       = ST_BLANK;
    if (visible)
      state_next = ST_ACTIVE;
    else if (pre)
      state_next = ST_GUARD;
    frame_start_next = (state_next == ST_GUARD) && (state_reg != ST_GUARD) &&
                       (i_vpos == V_LAST_L);

    grant0      = 1'b0;
    grant1      = 1'b0;
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    // Hold the memory port idle while reset is asserted.
    if (!i_rst) begin
      if (i_rd_req) begin
        o_mem_addr = i_rd_addr;
      end else if (state_reg == ST_BLANK) begin
        if (i_wr0_valid && i_wr1_valid) begin
          grant0 = rr_reg;
          grant1 = !rr_reg;
        end else begin
          grant0 = i_wr0_valid;
          grant1 = i_wr1_valid;
        end
        if (grant0) begin
          o_mem_addr  = i_wr0_addr;
          o_mem_wdata = i_wr0_data;
          o_mem_we    = 1'b1;
        end else if (grant1) begin
          o_mem_addr  = i_wr1_addr;
          o_mem_wdata = i_wr1_data;
          o_mem_we    = 1'b1;
        end
      end
    end
    o_wr0_ready = grant0;
    o_wr1_ready = grant1;
    rr_next     = grant1 ? 1'b1 : (grant0 ? 1'b0 : rr_reg);
  end

  // Window state, round-robin pointer, read-valid pipe and frame pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg       <= ST_BLANK;
      rr_reg          <= 1'b0;
      rd_valid_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rr_reg          <= rr_next;
      rd_valid_reg    <= i_rd_req;
      frame_start_reg <= frame_start_next;
    end
  end

  // The RAM returns data one cycle after the address, lining up with the
  // registered request; the data bus is forced to zero when not valid.
  assign o_rd_valid    = rd_valid_reg;
  assign o_rd_data     = rd_valid_reg ? i_mem_rdata : '0;
  assign o_state       = state_reg;
  assign o_frame_start = frame_start_reg;

endmodule

// File: tb/tb_video_mem_scheduler.sv
// Testbench for video_mem_scheduler: table of single-cycle window and
// arbitration vectors, then hand-written reset, round-robin, read/write
// collision and frame-wrap sequences.
module tb_video_mem_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [9:0]  i_hpos, i_vpos;
  logic        i_rd_req;
  logic [12:0] i_rd_addr;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic        i_wr0_valid, i_wr1_valid;
  logic [12:0] i_wr0_addr, i_wr1_addr;
  logic [7:0]  i_wr0_data, i_wr1_data;
  logic        o_wr0_ready, o_wr1_ready;
  logic [12:0] o_mem_addr;
  logic        o_mem_we;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  i_mem_rdata;
  logic [1:0]  o_state;
  logic        o_frame_start;

  int tests = 0;
  int fails = 0;

  localparam logic [12:0] RD_A  = 13'h111;
  localparam logic [12:0] W0_A  = 13'h0AA;
  localparam logic [12:0] W1_A  = 13'h155;
  localparam logic [7:0]  W0_D  = 8'h5A;
  localparam logic [7:0]  W1_D  = 8'hC3;
  localparam logic [1:0]  S_B   = 2'b00;
  localparam logic [1:0]  S_G   = 2'b01;
  localparam logic [1:0]  S_A   = 2'b10;

  video_mem_scheduler dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_hpos       (i_hpos),
    .i_vpos       (i_vpos),
    .i_rd_req     (i_rd_req),
    .i_rd_addr    (i_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_rd_valid   (o_rd_valid),
    .i_wr0_valid  (i_wr0_valid),
    .i_wr0_addr   (i_wr0_addr),
    .i_wr0_data   (i_wr0_data),
    .o_wr0_ready  (o_wr0_ready),
    .i_wr1_valid  (i_wr1_valid),
    .i_wr1_addr   (i_wr1_addr),
    .i_wr1_data   (i_wr1_data),
    .o_wr1_ready  (o_wr1_ready),
    .o_mem_addr   (o_mem_addr),
    .o_mem_we     (o_mem_we),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata),
    .o_state      (o_state),
    .o_frame_start(o_frame_start)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        rd;
    logic        w0;
    logic        w1;
    logic [1:0]  st;
    logic        we;
    logic        r0;
    logic        r1;
    logic        fs;
    logic [12:0] addr;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int h, input int v, input logic rd, input logic w0,
                              input logic w1, input logic [1:0] st, input logic we,
                              input logic r0, input logic r1, input logic fs,
                              input logic [12:0] addr);
    vec_t t;
    t.hpos = 10'(h); t.vpos = 10'(v); t.rd = rd; t.w0 = w0; t.w1 = w1;
    t.st = st; t.we = we; t.r0 = r0; t.r1 = r1; t.fs = fs; t.addr = addr;
    return t;
  endfunction

  initial begin
    //           hpos vpos rd w0 w1 state we r0 r1 fs addr
    vecs[0]  = mk(100,  10, 0, 1, 0, S_A, 0, 0, 0, 0, 13'h0);
    vecs[1]  = mk(640,  10, 0, 1, 0, S_B, 1, 1, 0, 0, W0_A);
    vecs[2]  = mk(700,  10, 0, 0, 1, S_B, 1, 0, 1, 0, W1_A);
    vecs[3]  = mk(798,  10, 0, 1, 0, S_G, 0, 0, 0, 0, 13'h0);
    vecs[4]  = mk(799,  10, 0, 0, 1, S_G, 0, 0, 0, 0, 13'h0);
    vecs[5]  = mk(0,    11, 0, 1, 0, S_A, 0, 0, 0, 0, 13'h0);
    vecs[6]  = mk(798, 479, 0, 1, 0, S_B, 1, 1, 0, 0, W0_A);
    vecs[7]  = mk(798, 478, 0, 1, 0, S_G, 0, 0, 0, 0, 13'h0);
    vecs[8]  = mk(100, 500, 0, 0, 1, S_B, 1, 0, 1, 0, W1_A);
    vecs[9]  = mk(798, 524, 0, 1, 0, S_G, 0, 0, 0, 1, 13'h0);
    vecs[10] = mk(0,     0, 1, 0, 0, S_A, 0, 0, 0, 0, RD_A);
    vecs[11] = mk(700,  10, 1, 1, 0, S_B, 0, 0, 0, 0, RD_A);
    vecs[12] = mk(797,  10, 0, 1, 0, S_B, 1, 1, 0, 0, W0_A);
    vecs[13] = mk(639, 479, 0, 0, 0, S_A, 0, 0, 0, 0, 13'h0);
    vecs[14] = mk(640, 480, 0, 0, 0, S_B, 0, 0, 0, 0, 13'h0);

    i_rst = 1'b1;
    i_hpos = 10'd0; i_vpos = 10'd0;
    i_rd_req = 1'b0; i_rd_addr = RD_A;
    i_wr0_valid = 1'b0; i_wr0_addr = W0_A; i_wr0_data = W0_D;
    i_wr1_valid = 1'b0; i_wr1_addr = W1_A; i_wr1_data = W1_D;
    i_mem_rdata = 8'h3C;
    #1;
    chk("reset_state", 32'(o_state), 32'(S_B));
    chk("reset_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("reset_frame_start", 32'(o_frame_start), 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Table: each vector is held for one clock and checked just after the edge.
    for (int i = 0; i < 15; i++) begin
      @(negedge i_clk);
      i_hpos = vecs[i].hpos; i_vpos = vecs[i].vpos;
      i_rd_req = vecs[i].rd; i_wr0_valid = vecs[i].w0; i_wr1_valid = vecs[i].w1;
      @(posedge i_clk);
      #1;
      $display("[TB] vec %0d hpos=%0d vpos=%0d state=%0b we=%0b addr=0x%0h",
               i, vecs[i].hpos, vecs[i].vpos, o_state, o_mem_we, o_mem_addr);
      chk($sformatf("vec%0d_state", i), 32'(o_state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_we", i), 32'(o_mem_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d_r0", i), 32'(o_wr0_ready), 32'(vecs[i].r0));
      chk($sformatf("vec%0d_r1", i), 32'(o_wr1_ready), 32'(vecs[i].r1));
      chk($sformatf("vec%0d_addr", i), 32'(o_mem_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_fs", i), 32'(o_frame_start), 32'(vecs[i].fs));
      chk($sformatf("vec%0d_rvalid", i), 32'(o_rd_valid), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_rdata", i), 32'(o_rd_data), vecs[i].rd ? 32'h3C : 32'h0);
      if (vecs[i].we)
        chk($sformatf("vec%0d_wdata", i), 32'(o_mem_wdata),
            vecs[i].r0 ? 32'(W0_D) : 32'(W1_D));
    end

    // Reset in the middle of a visible line with a read in flight.
    @(negedge i_clk);
    i_hpos = 10'd100; i_vpos = 10'd10; i_rd_req = 1'b1;
    i_wr0_valid = 1'b0; i_wr1_valid = 1'b0;
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    $display("[TB] async reset: state=%0b rd_valid=%0b we=%0b", o_state, o_rd_valid, o_mem_we);
    chk("async_rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("async_rst_state", 32'(o_state), 32'(S_B));
    chk("async_rst_we", 32'(o_mem_we), 32'd0);
    chk("async_rst_addr", 32'(o_mem_addr), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0; i_rd_req = 1'b0; i_hpos = 10'd700; i_vpos = 10'd10;

    // Both writers requesting from reset: wr1, wr0, wr1, wr0.
    @(negedge i_clk);
    i_wr0_valid = 1'b1; i_wr1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin
        @(posedge i_clk);
        #1;
      end
      $display("[TB] rr grant %0d: r0=%0b r1=%0b addr=0x%0h", k, o_wr0_ready, o_wr1_ready, o_mem_addr);
      chk($sformatf("rr%0d_r1", k), 32'(o_wr1_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_r0", k), 32'(o_wr0_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("rr%0d_addr", k), 32'(o_mem_addr), (k % 2 == 0) ? 32'(W1_A) : 32'(W0_A));
    end

    // Read collides with a wr1 request in blanking: read first, write next.
    @(negedge i_clk);
    i_wr0_valid = 1'b0; i_wr1_valid = 1'b1; i_rd_req = 1'b1; i_mem_rdata = 8'hA5;
    #1;
    $display("[TB] collide: r1=%0b we=%0b addr=0x%0h", o_wr1_ready, o_mem_we, o_mem_addr);
    chk("collide_r1_stall", 32'(o_wr1_ready), 32'd0);
    chk("collide_we", 32'(o_mem_we), 32'd0);
    chk("collide_addr", 32'(o_mem_addr), 32'(RD_A));
    @(posedge i_clk);
    #1;
    i_rd_req = 1'b0;
    #1;
    $display("[TB] after read: rd_valid=%0b rd_data=0x%0h r1=%0b", o_rd_valid, o_rd_data, o_wr1_ready);
    chk("collide_rd_valid", 32'(o_rd_valid), 32'd1);
    chk("collide_rd_data", 32'(o_rd_data), 32'hA5);
    chk("collide_r1_grant", 32'(o_wr1_ready), 32'd1);
    chk("collide_w_addr", 32'(o_mem_addr), 32'(W1_A));
    chk("collide_w_data", 32'(o_mem_wdata), 32'(W1_D));
    @(posedge i_clk);
    #1;
    i_wr1_valid = 1'b0;
    #1;
    chk("collide_rd_valid_off", 32'(o_rd_valid), 32'd0);

    // Last line of the frame: guard spans the hpos wrap into line 0.
    begin
      int fs_count;
      logic [9:0] hs[6];
      logic [9:0] vs[6];
      logic [1:0] es[6];
      logic       efs[6];
      hs  = '{10'd796, 10'd797, 10'd798, 10'd799, 10'd0, 10'd1};
      vs  = '{10'd524, 10'd524, 10'd524, 10'd524, 10'd0, 10'd0};
      es  = '{S_B, S_B, S_G, S_G, S_A, S_A};
      efs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      fs_count = 0;
      for (int s = 0; s < 6; s++) begin
        @(negedge i_clk);
        i_hpos = hs[s]; i_vpos = vs[s]; i_wr0_valid = 1'b1;
        @(posedge i_clk);
        #1;
        $display("[TB] wrap %0d: hpos=%0d vpos=%0d state=%0b fs=%0b r0=%0b",
                 s, hs[s], vs[s], o_state, o_frame_start, o_wr0_ready);
        if (o_frame_start) fs_count++;
        chk($sformatf("wrap%0d_state", s), 32'(o_state), 32'(es[s]));
        chk($sformatf("wrap%0d_fs", s), 32'(o_frame_start), 32'(efs[s]));
        chk($sformatf("wrap%0d_r0", s), 32'(o_wr0_ready), (es[s] == S_B) ? 32'd1 : 32'd0);
      end
      chk("frame_start_count", 32'(fs_count), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_mem_scheduler.md
Name: video_mem_scheduler

Overview:
- Time-division scheduler for the single-port pixel memory behind the VGA scanout.
- Three requesters share the memory:
  - the scanout read port, with absolute priority;
  - two write requesters (game logic = wr0, loader = wr1), round-robin between themselves.
- Writes are confined to the blanking windows, with a guard band before each visible line so scanout never sees a write collision.
- Sits between the sync generator's hpos/vpos counters and the frame-buffer RAM.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_TOTAL, 800, total pixel clocks per line
- V_VISIBLE, 480, visible lines per frame
- V_TOTAL, 525, total lines per frame
- GUARD, 2, cycles before a visible line during which writes are blocked (1..8)
- ADDR_W, 13, memory address width
- DATA_W, 8, memory data width

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  asynchronous, active-high reset
- i_hpos  in  10  horizontal counter from sync generator
- i_vpos  in  10  vertical counter from sync generator
- i_rd_req  in  1  scanout read request (single cycle)
- i_rd_addr  in  ADDR_W  scanout read address
- o_rd_data  out  DATA_W  read data
- o_rd_valid  out  1  read data valid
- i_wr0_valid  in  1  writer 0 request
- i_wr0_addr  in  ADDR_W  writer 0 address
- i_wr0_data  in  DATA_W  writer 0 data
- o_wr0_ready  out  1  writer 0 accepted this cycle
- i_wr1_valid, i_wr1_addr, i_wr1_data, o_wr1_ready: same as wr0, for writer 1
- o_mem_addr  out  ADDR_W  RAM address
- o_mem_we  out  1  RAM write enable
- o_mem_wdata  out  DATA_W  RAM write data
- i_mem_rdata  in  DATA_W  RAM read data (1-cycle latency)
- o_state  out  2  00=BLANK, 01=GUARD, 10=ACTIVE
- o_frame_start  out  1  one-cycle pulse on entry to line 0 GUARD

Behaviour:
- Reset (async assert, sync release): state=BLANK, rr pointer=wr0, and the following outputs are 0:
  - o_rd_valid, o_rd_data, o_mem_we, o_mem_addr, o_mem_wdata;
  - o_wr0_ready, o_wr1_ready;
  - o_frame_start.
- Reset mid-transfer discards any pending o_rd_valid.
- Window decode (combinational from i_hpos/i_vpos):
  - visible = (vpos < V_VISIBLE) && (hpos < H_VISIBLE).
  - pre = hpos >= H_TOTAL-GUARD, and either:
    - vpos < V_VISIBLE-1, or
    - vpos == V_TOTAL-1 (the line before line 0).
- State register (updated every clock, 1-cycle lag compensated by GUARD):
  - next = ACTIVE if visible;
  - else GUARD if pre;
  - else BLANK.
  - All transitions are permitted directly (e.g. ACTIVE->BLANK at end of visible line, BLANK->GUARD->ACTIVE).
- o_frame_start: registered pulse, asserted the cycle state enters GUARD while vpos == V_TOTAL-1.
- Arbitration, combinational on the registered state, evaluated each cycle:
  1. i_rd_req=1: mem_addr=i_rd_addr, mem_we=0, both ready=0. Allowed in every state.
  2. Else if state==BLANK and a writer is valid:
     - grant the single valid writer;
     - if both are valid, grant the writer not pointed to by rr (rr holds the last granted writer).
     - Grant drives mem_addr/mem_wdata from that writer, mem_we=1, and its ready=1.
  3. Else: mem_we=0, mem_addr=0, all ready=0.
- Writer handshake: transfer occurs when valid && ready in the same cycle.
  - A writer holds valid/addr/data stable until ready.
  - Ready never asserts in GUARD or ACTIVE.
- rr pointer updates only on a granted write and points to the writer just served; with a single requester it still updates.
- Read pipeline: o_rd_valid = registered i_rd_req; o_rd_data = i_mem_rdata, qualified by o_rd_valid. Throughput is 1 read/cycle, latency 1.
- Simultaneous read and write in BLANK: the read wins, the writer waits (no drop).
- Wrap-around:
  - GUARD spans the hpos wrap to 0 at line end;
  - the last line of the frame (V_TOTAL-1) enters GUARD for line 0;
  - line V_VISIBLE-1 does not enter GUARD.
- Outputs other than o_rd_data, o_rd_valid, o_state and o_frame_start are combinational from registered state plus inputs.

Test Plan:
- Reset asserted mid-frame with i_rd_req=1 -> o_rd_valid=0, o_state=00, o_mem_we=0 immediately, before the next clock edge.
- hpos=100, vpos=10, wr0_valid=1 -> o_state=10, o_wr0_ready=0 until state==BLANK (hpos=641 after lag); then o_mem_we=1 with the wr0 addr/data for exactly one cycle.
- BLANK, wr0 and wr1 both valid continuously for 4 cycles after reset -> grants in order wr1, wr0, wr1, wr0.
- BLANK, i_rd_req=1 with wr1_valid=1, i_mem_rdata=0xA5 -> wr1 stalled that cycle; next cycle o_rd_valid=1, o_rd_data=0xA5; wr1 granted the following cycle.
- vpos=10, hpos=798..799 (GUARD=2) -> o_state=01 during those cycles, no write granted; line 479 at hpos=798 -> o_state=00.
- vpos=524, hpos=798 -> o_frame_start pulses once; o_state goes 01 then 10 at hpos=0 of line 0.
